// File: rtl/dcache_port_arbiter_pkg.sv
// dcache_port_arbiter_pkg
//   Shared definitions for the two-lane data-cache port arbiter: the arbiter
//   FSM state encoding and the lane index constants.
package dcache_port_arbiter_pkg;

  // IDLE   : free to issue a request from one of the lanes
  // WAIT_R : one read is outstanding and its response is owed to a lane
  // DRAIN  : an outstanding read was flushed; its response must be dropped
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  // Lane 0 carries the older instruction and wins fixed-priority arbitration.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Merges the two load/store lanes onto the single data-cache port. Lane 0
//   (older) has fixed priority, except that a request already presented to the
//   cache but not yet accepted stays granted until the cache takes it. Only one
//   read may be outstanding; its response is returned to the owning lane in the
//   same cycle it arrives. A flush drops any in-flight read response.
//
// Ports
//   clock, reset        : clock and synchronous active-high reset
//   flush               : pipeline flush
//   lN_valid / lN_ready : lane request handshake (N = 0, 1)
//   lN_op, lN_addr, lN_uncached, lN_awstrb, lN_wdata : lane request fields
//   lN_rvalid, lN_rdata : lane read response
//   dc_valid / dc_ready : cache request handshake
//   dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata : cache request fields
//   dc_rvalid, dc_rdata : cache read response
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,

  input  logic              l0_valid,
  output logic              l0_ready,
  input  logic              l0_op,
  input  logic [ADDR_W-1:0] l0_addr,
  input  logic              l0_uncached,
  input  logic [3:0]        l0_awstrb,
  input  logic [DATA_W-1:0] l0_wdata,
  output logic              l0_rvalid,
  output logic [DATA_W-1:0] l0_rdata,

  input  logic              l1_valid,
  output logic              l1_ready,
  input  logic              l1_op,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_uncached,
  input  logic [3:0]        l1_awstrb,
  input  logic [DATA_W-1:0] l1_wdata,
  output logic              l1_rvalid,
  output logic [DATA_W-1:0] l1_rdata,

  output logic              dc_valid,
  input  logic              dc_ready,
  output logic              dc_op,
  output logic [ADDR_W-1:0] dc_addr,
  output logic              dc_uncached,
  output logic [3:0]        dc_awstrb,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_rvalid,
  input  logic [DATA_W-1:0] dc_rdata
);

  arb_state_e state;
  logic       owner;
  logic       hold_vld;
  logic       hold_lane;

  logic       grant;
  logic       grant_valid;
  logic       issue_ok;
  logic       resp_ok;

  // A stalled request keeps its grant so the cache sees a stable request;
  // otherwise lane 0 wins. With no lane valid the grant parks on lane 0.
  always_comb begin
    grant = LANE0;
    if (hold_vld) begin
      grant = hold_lane;
    end else if (l0_valid) begin
      grant = LANE0;
    end else if (l1_valid) begin
      grant = LANE1;
    end
  end

  assign grant_valid = (grant == LANE1) ? l1_valid : l0_valid;

  // Reset is folded in so nothing handshakes during the reset cycle, even if
  // the state register still holds a busy state.
  assign issue_ok = ~reset & (state == IDLE) & ~flush;
  assign resp_ok  = ~reset & (state == WAIT_R) & ~flush & dc_rvalid;

  assign dc_valid    = issue_ok & grant_valid;
  assign dc_op       = (grant == LANE1) ? l1_op       : l0_op;
  assign dc_addr     = (grant == LANE1) ? l1_addr     : l0_addr;
  assign dc_uncached = (grant == LANE1) ? l1_uncached : l0_uncached;
  assign dc_awstrb   = (grant == LANE1) ? l1_awstrb   : l0_awstrb;
  assign dc_wdata    = (grant == LANE1) ? l1_wdata    : l0_wdata;

  assign l0_ready = issue_ok & (grant == LANE0) & dc_ready;
  assign l1_ready = issue_ok & (grant == LANE1) & dc_ready;

  assign l0_rvalid = resp_ok & (owner == LANE0);
  assign l1_rvalid = resp_ok & (owner == LANE1);
  assign l0_rdata  = dc_rdata;
  assign l1_rdata  = dc_rdata;

  // Arbiter FSM. Writes complete on acceptance and keep the FSM in IDLE;
  // reads move to WAIT_R until the response arrives. A flush while waiting
  // diverts to DRAIN so the late response is swallowed rather than delivered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= LANE0;
      hold_vld  <= 1'b0;
      hold_lane <= LANE0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            hold_vld <= 1'b0;
          end else if (dc_valid) begin
            if (!dc_ready) begin
              hold_vld  <= 1'b1;
              hold_lane <= grant;
            end else begin
              hold_vld <= 1'b0;
              if (!dc_op) begin
                state <= WAIT_R;
                owner <= grant;
              end
            end
          end
        end
        WAIT_R: begin
          if (dc_rvalid) begin
            state <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dc_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//   Directed scenarios for priority, hold, back-to-back writes, flush and
//   reset handling, followed by a randomized run checked against a
//   transaction-level model of the arbiter.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset, flush;
  logic              l0_valid, l0_ready, l0_op, l0_uncached, l0_rvalid;
  logic [ADDR_W-1:0] l0_addr;
  logic [3:0]        l0_awstrb;
  logic [DATA_W-1:0] l0_wdata, l0_rdata;
  logic              l1_valid, l1_ready, l1_op, l1_uncached, l1_rvalid;
  logic [ADDR_W-1:0] l1_addr;
  logic [3:0]        l1_awstrb;
  logic [DATA_W-1:0] l1_wdata, l1_rdata;
  logic              dc_valid, dc_ready, dc_op, dc_uncached, dc_rvalid;
  logic [ADDR_W-1:0] dc_addr;
  logic [3:0]        dc_awstrb;
  logic [DATA_W-1:0] dc_wdata, dc_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .l0_valid(l0_valid), .l0_ready(l0_ready), .l0_op(l0_op), .l0_addr(l0_addr),
    .l0_uncached(l0_uncached), .l0_awstrb(l0_awstrb), .l0_wdata(l0_wdata),
    .l0_rvalid(l0_rvalid), .l0_rdata(l0_rdata),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
    .l1_uncached(l1_uncached), .l1_awstrb(l1_awstrb), .l1_wdata(l1_wdata),
    .l1_rvalid(l1_rvalid), .l1_rdata(l1_rdata),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_op(dc_op), .dc_addr(dc_addr),
    .dc_uncached(dc_uncached), .dc_awstrb(dc_awstrb), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge in the middle of the cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; flush = 1'b0;
    l0_valid = 1'b0; l0_op = 1'b0; l0_addr = '0; l0_uncached = 1'b0;
    l0_awstrb = 4'h0; l0_wdata = '0;
    l1_valid = 1'b0; l1_op = 1'b0; l1_addr = '0; l1_uncached = 1'b0;
    l1_awstrb = 4'h0; l1_wdata = '0;
    dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; l0_valid = 1'b1; l1_valid = 1'b1; dc_ready = 1'b1;
    dc_rvalid = 1'b1;
    @(negedge clock);
    checks++;
    if ({dc_valid, l0_ready, l1_ready, l0_rvalid, l1_rvalid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %05b exp 00000",
               {dc_valid, l0_ready, l1_ready, l0_rvalid, l1_rvalid});
    end
    tick();
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL reset_state got %0d exp %0d", dut.state, IDLE);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    l0_valid = 1'b1; l0_op = 1'b0; l0_addr = 32'h1000;
    l1_valid = 1'b1; l1_op = 1'b0; l1_addr = 32'h2000;
    dc_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (dc_valid !== 1'b1 || dc_addr !== 32'h1000) begin
      errors++;
      $display("[TB] FAIL simul_addr got v=%0b a=%h exp v=1 a=1000", dc_valid, dc_addr);
    end
    checks++;
    if (l0_ready !== 1'b1 || l1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_ready got %0b%0b exp 10", l0_ready, l1_ready);
    end
    tick();
    l0_valid = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if (l0_rvalid !== 1'b1 || l1_rvalid !== 1'b0 || l0_rdata !== 32'hDEADBEEF
        || dc_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_resp got rv=%0b%0b d=%h dcv=%0b exp rv=10 d=deadbeef dcv=0",
               l0_rvalid, l1_rvalid, l0_rdata, dc_valid);
    end
    tick();
    dc_rvalid = 1'b0;
    @(negedge clock);
    checks++;
    if (dc_valid !== 1'b1 || dc_addr !== 32'h2000 || l1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_second got v=%0b a=%h r1=%0b exp v=1 a=2000 r1=1",
               dc_valid, dc_addr, l1_ready);
    end
    tick();
    l1_valid = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'h12345678;
    @(negedge clock);
    checks++;
    if (l1_rvalid !== 1'b1 || l0_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_resp2 got rv=%0b%0b exp 01", l0_rvalid, l1_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_hold();
    clear_inputs();
    l1_valid = 1'b1; l1_op = 1'b1; l1_addr = 32'h3000; l1_wdata = 32'hA5A5A5A5;
    l1_awstrb = 4'hF;
    @(negedge clock);
    tick();
    l0_valid = 1'b1; l0_op = 1'b0; l0_addr = 32'h4000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (dc_valid !== 1'b1 || dc_addr !== 32'h3000 || l0_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable got v=%0b a=%h r0=%0b exp v=1 a=3000 r0=0",
                 dc_valid, dc_addr, l0_ready);
      end
      tick();
    end
    dc_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (dc_addr !== 32'h3000 || l1_ready !== 1'b1 || l0_ready !== 1'b0
        || dc_op !== 1'b1 || dc_wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("[TB] FAIL hold_accept got a=%h r=%0b%0b op=%0b exp a=3000 r=01 op=1",
               dc_addr, l0_ready, l1_ready, dc_op);
    end
    tick();
    l1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (dc_addr !== 32'h4000 || l0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_next got a=%h r0=%0b exp a=4000 r0=1", dc_addr, l0_ready);
    end
    tick();
    l0_valid = 1'b0; dc_rvalid = 1'b1;
    @(negedge clock);
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    l0_valid = 1'b1; l0_op = 1'b1; l0_addr = 32'h5000; l0_awstrb = 4'b0011;
    l0_wdata = 32'h0000BEEF;
    l1_valid = 1'b1; l1_op = 1'b0; l1_addr = 32'h6000; l1_uncached = 1'b1;
    dc_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (dc_op !== 1'b1 || dc_awstrb !== 4'b0011 || dc_addr !== 32'h5000
        || l0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_write got op=%0b s=%b a=%h r0=%0b exp op=1 s=0011 a=5000 r0=1",
               dc_op, dc_awstrb, dc_addr, l0_ready);
    end
    tick();
    l0_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (dc_valid !== 1'b1 || dc_addr !== 32'h6000 || l1_ready !== 1'b1
        || dc_uncached !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_next got v=%0b a=%h r1=%0b u=%0b exp v=1 a=6000 r1=1 u=1",
               dc_valid, dc_addr, l1_ready, dc_uncached);
    end
    tick();
    l1_valid = 1'b0; dc_rvalid = 1'b1;
    @(negedge clock);
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_wait();
    clear_inputs();
    l1_valid = 1'b1; l1_op = 1'b0; l1_addr = 32'h7000; dc_ready = 1'b1;
    @(negedge clock);
    tick();
    l1_valid = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (l0_rvalid !== 1'b0 || l1_rvalid !== 1'b0 || dc_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_wait_c%0d got rv=%0b%0b dcv=%0b exp 00 0",
                 i, l0_rvalid, l1_rvalid, dc_valid);
      end
      tick();
      flush = 1'b0;
      dc_rvalid = (i == 1);
    end
    dc_rvalid = 1'b0;
    @(negedge clock);
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL flush_wait_idle got %0d exp %0d", dut.state, IDLE);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_same_cycle();
    clear_inputs();
    l0_valid = 1'b1; l0_op = 1'b0; l0_addr = 32'h9000; dc_ready = 1'b1;
    @(negedge clock);
    tick();
    l0_valid = 1'b0; flush = 1'b1; dc_rvalid = 1'b1;
    @(negedge clock);
    checks++;
    if (l0_rvalid !== 1'b0 || l1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_same got rv=%0b%0b exp 00", l0_rvalid, l1_rvalid);
    end
    tick();
    clear_inputs();
    l1_valid = 1'b1; l1_op = 1'b1; l1_addr = 32'hA000; dc_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (dut.state !== IDLE || dc_valid !== 1'b1 || dc_addr !== 32'hA000) begin
      errors++;
      $display("[TB] FAIL flush_same_idle got st=%0d v=%0b a=%h exp st=0 v=1 a=a000",
               dut.state, dc_valid, dc_addr);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    l1_valid = 1'b1; l1_op = 1'b0; l1_addr = 32'hB000; dc_ready = 1'b1;
    @(negedge clock);
    tick();
    l1_valid = 1'b0; reset = 1'b1; dc_rvalid = 1'b1; l0_valid = 1'b1;
    @(negedge clock);
    checks++;
    if ({dc_valid, l0_ready, l1_ready, l0_rvalid, l1_rvalid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs got %05b exp 00000",
               {dc_valid, l0_ready, l1_ready, l0_rvalid, l1_rvalid});
    end
    tick();
    clear_inputs();
    dc_rvalid = 1'b1;
    @(negedge clock);
    checks++;
    if (dut.state !== IDLE || l0_rvalid !== 1'b0 || l1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_stray got st=%0d rv=%0b%0b exp st=0 rv=00",
               dut.state, l0_rvalid, l1_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  // Randomized run. The model tracks transactions rather than FSM states:
  // which lane (if any) is owed the outstanding read response, whether that
  // response has been doomed by a flush, and which lane's request is parked
  // at the cache port waiting for acceptance.
  task automatic test_random();
    int            owed;
    bit            doomed;
    int            parked;
    bit            v[2];
    bit            op[2];
    logic [31:0]   addr[2];
    logic [3:0]    strb[2];
    logic [31:0]   wd[2];
    bit            unc[2];
    int            gl;
    bit            exp_dcv;
    bit            exp_hs[2];
    bit            exp_rv[2];

    owed = -1; doomed = 1'b0; parked = -1;
    v[0] = 1'b0; v[1] = 1'b0;
    clear_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && ($urandom_range(1, 0) == 1)) begin
          v[n]    = 1'b1;
          op[n]   = 1'($urandom_range(1, 0));
          addr[n] = $urandom;
          strb[n] = 4'($urandom_range(15, 0));
          wd[n]   = $urandom;
          unc[n]  = 1'($urandom_range(1, 0));
        end
      end
      l0_valid = v[0]; l0_op = op[0]; l0_addr = addr[0]; l0_awstrb = strb[0];
      l0_wdata = wd[0]; l0_uncached = unc[0];
      l1_valid = v[1]; l1_op = op[1]; l1_addr = addr[1]; l1_awstrb = strb[1];
      l1_wdata = wd[1]; l1_uncached = unc[1];
      dc_ready  = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(9, 0) == 0);
      dc_rvalid = (owed != -1) && ($urandom_range(2, 0) == 0);
      dc_rdata  = $urandom;

      if (parked != -1) gl = parked;
      else if (v[0]) gl = 0;
      else if (v[1]) gl = 1;
      else gl = -1;
      exp_dcv = (owed == -1) && !flush && (gl != -1);
      for (int n = 0; n < 2; n++) begin
        exp_hs[n] = exp_dcv && dc_ready && (gl == n);
        exp_rv[n] = (owed == n) && !doomed && dc_rvalid && !flush;
      end

      @(negedge clock);
      checks++;
      if (dc_valid !== exp_dcv) begin
        errors++;
        $display("[TB] FAIL rand_dcv cyc %0d got %0b exp %0b", cyc, dc_valid, exp_dcv);
      end
      if (exp_dcv) begin
        checks++;
        if (dc_addr !== addr[gl] || dc_op !== op[gl] || dc_awstrb !== strb[gl]
            || dc_wdata !== wd[gl] || dc_uncached !== unc[gl]) begin
          errors++;
          $display("[TB] FAIL rand_fields cyc %0d got a=%h op=%0b exp a=%h op=%0b lane %0d",
                   cyc, dc_addr, dc_op, addr[gl], op[gl], gl);
        end
      end
      checks++;
      if ((l0_valid & l0_ready) !== exp_hs[0] || (l1_valid & l1_ready) !== exp_hs[1]) begin
        errors++;
        $display("[TB] FAIL rand_handshake cyc %0d got %0b%0b exp %0b%0b", cyc,
                 l0_valid & l0_ready, l1_valid & l1_ready, exp_hs[0], exp_hs[1]);
      end
      checks++;
      if (l0_rvalid !== exp_rv[0] || l1_rvalid !== exp_rv[1]
          || l0_rdata !== dc_rdata || l1_rdata !== dc_rdata) begin
        errors++;
        $display("[TB] FAIL rand_resp cyc %0d got rv=%0b%0b exp rv=%0b%0b", cyc,
                 l0_rvalid, l1_rvalid, exp_rv[0], exp_rv[1]);
      end

      if (owed != -1) begin
        if (dc_rvalid) begin
          owed = -1; doomed = 1'b0;
        end else if (flush) begin
          doomed = 1'b1;
        end
      end else if (flush) begin
        parked = -1;
      end else if (exp_dcv) begin
        if (dc_ready) begin
          parked = -1;
          if (!op[gl]) begin
            owed = gl; doomed = 1'b0;
          end
          v[gl] = 1'b0;
        end else begin
          parked = gl;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_simultaneous();
    test_hold();
    test_back_to_back();
    test_flush_wait();
    test_flush_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, load/store data width.
REQ-003 SHALL have port clock, in, 1, the single clock.
REQ-004 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, in, 1, pipeline flush (OR of both EXM flush outputs).
REQ-006 SHALL have lane ports lN_valid, in, 1 and lN_ready, out, 1 for N=0,1; lane 0 is the older instruction.
REQ-007 SHALL have lane request ports lN_op (in, 1, 0=read 1=write), lN_addr (in, ADDR_W), lN_uncached (in, 1), lN_awstrb (in, 4), lN_wdata (in, DATA_W).
REQ-008 SHALL have lane response ports lN_rvalid (out, 1) and lN_rdata (out, DATA_W).
REQ-009 SHALL have dcache-side ports dc_valid (out, 1), dc_ready (in, 1), dc_op (out, 1), dc_addr (out, ADDR_W), dc_uncached (out, 1), dc_awstrb (out, 4), dc_wdata (out, DATA_W), dc_rvalid (in, 1), dc_rdata (in, DATA_W).

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_R and DRAIN, plus registers owner (1 bit), hold_vld (1 bit) and hold_lane (1 bit).
REQ-011 SHALL, in IDLE with hold_vld=0, grant lane 0 if l0_valid, else lane 1 if l1_valid (fixed priority).
REQ-012 SHALL, in IDLE with hold_vld=1, force the grant to hold_lane regardless of lane 0 priority.
REQ-013 SHALL drive dc_valid = IDLE & ~flush & (valid of the granted lane), with all dc_* request fields muxed combinationally from the granted lane.
REQ-014 SHALL drive lN_ready = IDLE & ~flush & granted==N & dc_ready; the non-granted lane's ready SHALL be 0.
REQ-015 SHALL set hold_vld<=1 and hold_lane<=grant when dc_valid & ~dc_ready, so the presented request stays stable until accepted.
REQ-016 SHALL clear hold_vld when dc_valid & dc_ready.
REQ-017 SHALL remain in IDLE when a write is accepted (dc_op=1); writes need no response.
REQ-018 SHALL, when a read is accepted (dc_op=0), go to WAIT_R with owner<=grant.
REQ-019 SHALL present no dc_valid in WAIT_R or DRAIN: at most one outstanding read.
REQ-020 SHALL, in WAIT_R on dc_rvalid, drive l[owner]_rvalid=1 and l[owner]_rdata=dc_rdata in the same cycle (zero latency) and return to IDLE; the first new request may issue the following cycle.
REQ-021 SHALL keep lN_rvalid=0 except as specified in REQ-020; lN_rdata SHALL equal dc_rdata at all times.
REQ-022 SHALL, on flush in WAIT_R without dc_rvalid, go to DRAIN; in DRAIN, dc_rvalid SHALL be swallowed (no lane rvalid) and the FSM SHALL return to IDLE.
REQ-023 SHALL, on flush and dc_rvalid in the same WAIT_R cycle, discard the response and go to IDLE.
REQ-024 SHALL, on flush in IDLE, clear hold_vld and issue nothing that cycle; an accepted handshake is impossible in a flush cycle.
REQ-025 SHALL ignore lane valids while in WAIT_R or DRAIN; lanes are required to hold valid.

Reset
REQ-026 SHALL, on reset, set state=IDLE, owner=0, hold_vld=0, hold_lane=0; dc_valid, l0_ready, l1_ready, l0_rvalid and l1_rvalid SHALL be 0 in the reset cycle.
REQ-027 SHALL abandon any outstanding read when reset is asserted mid-operation; a later dc_rvalid in IDLE SHALL be ignored.

Structure
REQ-028 SHALL take the state encoding (IDLE/WAIT_R/DRAIN) and the lane index constants from the shared core package; ADDR_W and DATA_W remain module parameters.
REQ-029 SHALL be a single module with no sub-module; priority select and muxing stay inline.

Verification
REQ-030 SHALL test a simultaneous request: l0 read 0x1000 and l1 read 0x2000 both valid with dc_ready=1. Required: dc_addr=0x1000; l0_ready pulses; dc_rvalid with 0xDEADBEEF gives l0_rvalid only; 0x2000 issues the cycle after.
REQ-031 SHALL test the hold rule: l1 write 0x3000 presented with dc_ready=0, then l0 becomes valid. Required: dc_addr stays 0x3000 until dc_ready=1; l0 is granted next.
REQ-032 SHALL test a back-to-back write: l0 write with awstrb=4'b0011 and dc_ready=1. Required: FSM stays IDLE; the l1 request issues the next cycle.
REQ-033 SHALL test a flush in WAIT_R: l1 read accepted, flush pulsed, then dc_rvalid two cycles later. Required: l0_rvalid=l1_rvalid=0 throughout; IDLE after dc_rvalid.
REQ-034 SHALL test flush and dc_rvalid in the same cycle. Required: no lane rvalid; IDLE on the next cycle.
REQ-035 SHALL test reset while in WAIT_R. Required: all outputs 0, state IDLE; a subsequent stray dc_rvalid produces no lane rvalid.
